sha_sched_stream: RTL
=====================

Name: sha_sched_stream

Overview:
- Parametrised, flow-controlled SHA-2 message schedule expander; successor to the fixed 32-bit, 64-round free-running expander.
- Accepts the 16 message words of one block over a valid/ready input stream.
- Emits W[0..ROUNDS-1] over a valid/ready output stream to the compression core, with full back-pressure support.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) through parameters.

Parameters:
- WORD_W, 32, word width; legal values 32 (SHA-256 sigma set) or 64 (SHA-512 sigma set); any other value is an elaboration error.
- ROUNDS, 64, words emitted per block; must be ≥16. Use 64 for WORD_W=32 and 80 for WORD_W=64.
- CNT_W, 7, round counter width; must satisfy 2^CNT_W > ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_valid  in  1  input word valid.
- m_ready  out  1  block can accept an input word this cycle.
- m_data  in  WORD_W  message word M[t], big-endian word order, t=0..15.
- w_valid  out  1  output word valid.
- w_ready  in  1  consumer accepts the output word this cycle.
- w_data  out  WORD_W  schedule word W[t].
- w_last  out  1  high with W[ROUNDS-1].
- busy  out  1  high from the first accepted M[0] until W[ROUNDS-1] is accepted.

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high. On rst: state=LOAD, t=0, w_valid=0, w_data=0, w_last=0, busy=0, window contents don't-care.
  - rst overrides all other activity in the same cycle, including any handshake.
  - rst mid-block discards the partial block with no output.
- Handshakes:
  - Input transfer = m_valid & m_ready.
  - Output transfer = w_valid & w_ready.
  - Output slot free = !w_valid | w_ready.
- 16-entry shift window holds W[t-16..t-1]. A new word is shifted in only when it is also loaded into the output register.
- State LOAD:
  - m_ready = slot free.
  - On input transfer: w_data <= m_data, w_valid <= 1, window shifts, t <= t+1, busy <= 1.
  - After the transfer with t==15, go to EXPAND.
  - m_valid with slot not free: hold, m_ready=0.
- State EXPAND:
  - m_ready = 0.
  - When slot free: w_data <= sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^WORD_W; w_valid <= 1; window shifts; t <= t+1.
  - After the word with t==ROUNDS-1 is loaded, go to DRAIN.
- State DRAIN:
  - m_ready = 0.
  - On output transfer of W[ROUNDS-1]: w_valid <= 0, busy <= 0, t <= 0, state=LOAD.
  - DRAIN never overlaps with the next block's M[0]; one bubble cycle between blocks is accepted.
- w_last = w_valid & (index of held word == ROUNDS-1).
- Latency: W[t] appears on w_data the cycle after its input transfer (t<16) or slot-free cycle (t≥16).
- Sustained throughput: 1 word/cycle when w_ready=1 and m_valid=1.
- Stall: w_ready=0 freezes w_data, w_valid, w_last, window, t and state; no word is lost or duplicated.
- Sigma functions:
  - WORD_W=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- Counter t never exceeds ROUNDS-1; wrap to 0 only via DRAIN completion or rst.

Optional Feature:
- Macro SHA_SCHED_ROUND_IDX_EN.
- Defined: extra output port w_idx (CNT_W bits, registered alongside w_data) carries the round index of the held word.
  - Resets to 0 and freezes on stall.
  - w_last is derived from w_idx.
- Undefined: no w_idx port. w_last is produced from a single-bit registered flag set when W[ROUNDS-1] is loaded.
- Data behaviour is identical with and without the macro.

Test Plan:
- SHA-256 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1, m_valid=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; w_last only on W63; 64 consecutive output cycles.
- Same block, w_ready toggled by a random 50% pattern -> identical W0..W63 sequence versus a software model, no drop or duplicate, w_data stable while w_valid & !w_ready.
- WORD_W=64, ROUNDS=80, SHA-512 "abc" (M0=0x6162638000000000, M15=0x18) -> W0..W79 match the software model; w_last on W79.
- rst asserted after 20 outputs, then a fresh block -> w_valid=0 and busy=0 the cycle after rst; next output is M0 of the new block.
- Two back-to-back blocks with m_valid held high -> m_ready=0 from t=16 until W63 is accepted; second block's W0 arrives exactly one bubble cycle later; busy drops for that single cycle only.
- With SHA_SCHED_ROUND_IDX_EN defined -> w_idx steps 0..63 with each output transfer, holds during stalls, and is 0 after rst.

Source files
------------

// File: rtl/sha_sched_stream.sv
// Flow-controlled SHA-2 message schedule expander: 16 words in, W[0..ROUNDS-1] out.
// Optional macro SHA_SCHED_ROUND_IDX_EN adds the w_idx round-index output port.
module sha_sched_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [WORD_W-1:0] m_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic              w_last,
`ifdef SHA_SCHED_ROUND_IDX_EN
    output logic [CNT_W-1:0]  w_idx,
`endif
    output logic              busy
);

    generate
        if ((WORD_W != 32) && (WORD_W != 64)) begin : g_bad_word_w
            $error("sha_sched_stream: WORD_W must be 32 or 64");
        end
        if (ROUNDS < 16) begin : g_bad_rounds
            $error("sha_sched_stream: ROUNDS must be at least 16");
        end
        if ((2 ** CNT_W) <= ROUNDS) begin : g_bad_cnt_w
            $error("sha_sched_stream: CNT_W too narrow for ROUNDS");
        end
    endgenerate

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else              return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    typedef enum logic [1:0] {LOAD, EXPAND, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  t;
    logic [WORD_W-1:0] win [16];   // win[15] = W[t-1] ... win[0] = W[t-16]
    logic              slot_free;
    logic              in_xfer;
    logic              out_xfer;
    logic              load;
    logic              is_last_t;
    logic [WORD_W-1:0] exp_word;
    logic [WORD_W-1:0] new_word;

    assign slot_free = !w_valid || w_ready;
    assign out_xfer  = w_valid && w_ready;
    assign in_xfer   = m_valid && m_ready;
    assign is_last_t = (t == CNT_W'(ROUNDS - 1));
    assign exp_word  = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign load      = (state == LOAD) ? in_xfer : ((state == EXPAND) && slot_free);
    assign new_word  = (state == LOAD) ? m_data : exp_word;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (in_xfer) begin
                    if (is_last_t)              state_nxt = DRAIN;
                    else if (t == CNT_W'(15))   state_nxt = EXPAND;
                end
            end
            EXPAND:  if (slot_free && is_last_t) state_nxt = DRAIN;
            DRAIN:   if (out_xfer) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        m_ready = (state == LOAD) && slot_free;
    end

    // Output register stage: counter stays parked on ROUNDS-1 until the drain handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            t       <= '0;
            w_valid <= 1'b0;
            w_data  <= '0;
            busy    <= 1'b0;
        end else begin
            if (load) begin
                w_data  <= new_word;
                w_valid <= 1'b1;
                t       <= is_last_t ? t : t + CNT_W'(1);
            end else if (out_xfer) begin
                w_valid <= 1'b0;
                if (state == DRAIN) t <= '0;
            end
            if (in_xfer)
                busy <= 1'b1;
            else if ((state == DRAIN) && out_xfer)
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= new_word;
        end
    end

`ifdef SHA_SCHED_ROUND_IDX_EN
    always_ff @(posedge clk) begin
        if (rst)       w_idx <= '0;
        else if (load) w_idx <= t;
    end

    assign w_last = w_valid && (w_idx == CNT_W'(ROUNDS - 1));
`else
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst)           last_q <= 1'b0;
        else if (load)     last_q <= is_last_t;
        else if (out_xfer) last_q <= 1'b0;
    end

    assign w_last = w_valid && last_q;
`endif

endmodule
